bp_req_arbiter: RTL and testbench

//  Shares one BytePipe request port (feeding bpAxiMaster) between N_REQ requesters.

---
 rtl/bp_pkg.sv | 34 +++
 rtl/bp_owner_fifo.sv | 60 ++++++
 rtl/bp_req_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_bp_req_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// BytePipe shared definitions: bus widths, legal nBytes encodings, reply codes
// and the registered downstream request packet.
package bp_pkg;

   localparam int BP_ADDR_W = 64;
   localparam int BP_DATA_W = 64;
   localparam int BP_NB_W   = 4;

   localparam logic [BP_NB_W-1:0] BP_NB_1 = 4'd1;
   localparam logic [BP_NB_W-1:0] BP_NB_2 = 4'd2;
   localparam logic [BP_NB_W-1:0] BP_NB_4 = 4'd4;
   localparam logic [BP_NB_W-1:0] BP_NB_8 = 4'd8;

   typedef enum logic [1:0] {
      BP_RESP_OKAY   = 2'd0,
      BP_RESP_EXOKAY = 2'd1,
      BP_RESP_SLVERR = 2'd2,
      BP_RESP_DECERR = 2'd3
   } bp_resp_e;

   typedef struct packed {
      logic                 rnw;
      logic                 incr;
      logic                 prev;
      logic [BP_NB_W-1:0]   nbytes;
      logic [BP_ADDR_W-1:0] addr;
      logic [BP_DATA_W-1:0] data;
   } bp_pkt_t;

   function automatic logic bp_nbytes_legal(input logic [BP_NB_W-1:0] nb);
      return (nb == BP_NB_1) || (nb == BP_NB_2) || (nb == BP_NB_4) || (nb == BP_NB_8);
   endfunction

endpackage

// File: rtl/bp_owner_fifo.sv
// In-order record of which requester owns each outstanding read.
// Zero-latency head; push ignored when full, pop ignored when empty; flags registered.
module bp_owner_fifo #(
   parameter int W     = 1,
   parameter int DEPTH = 4
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_push,
   input  logic [W-1:0] i_push_dat,
   input  logic         i_pop,
   output logic [W-1:0] o_head_dat,
   output logic         o_full,
   output logic         o_empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [W-1:0]  r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_cnt;
   logic          r_full;
   logic          r_empty;

   logic          w_do_push;
   logic          w_do_pop;
   logic [CW-1:0] w_cnt_nxt;

   assign w_do_push = i_push && !r_full;
   assign w_do_pop  = i_pop && !r_empty;
   assign w_cnt_nxt = r_cnt + CW'(w_do_push) - CW'(w_do_pop);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
         r_cnt   <= w_cnt_nxt;
         r_full  <= (w_cnt_nxt == CW'(DEPTH));
         r_empty <= (w_cnt_nxt == '0);
      end
   end

   // Storage needs no reset: the empty flag guards every read of it.
   always_ff @(posedge i_clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_push_dat;
   end

   assign o_head_dat = r_mem[r_rd_ptr];
   assign o_full     = r_full;
   assign o_empty    = r_empty;

endmodule

// File: rtl/bp_req_arbiter.sv
// Round-robin share of one BytePipe request port among N_REQ sources; accept in T, o_dn_valid in T+1.
// Output stage holds under !i_dn_ready; reads stall when OUTSTANDING owners are recorded; replies routed in order.
module bp_req_arbiter
   import bp_pkg::*;
#(
   parameter int N_REQ       = 2,
   parameter int OUTSTANDING = 4
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic [N_REQ-1:0]           i_req_valid,
   output logic [N_REQ-1:0]           o_req_ready,
   input  logic [N_REQ-1:0]           i_req_readNotWrite,
   input  logic [N_REQ-1:0]           i_req_incrAddr,
   input  logic [N_REQ-1:0]           i_req_prevAddr,
   input  logic [BP_NB_W*N_REQ-1:0]   i_req_nBytes,
   input  logic [BP_ADDR_W*N_REQ-1:0] i_req_addr,
   input  logic [BP_DATA_W*N_REQ-1:0] i_req_data,
   output logic                       o_dn_valid,
   input  logic                       i_dn_ready,
   output logic                       o_dn_readNotWrite,
   output logic                       o_dn_incrAddr,
   output logic                       o_dn_prevAddr,
   output logic [BP_NB_W-1:0]         o_dn_nBytes,
   output logic [BP_ADDR_W-1:0]       o_dn_addr,
   output logic [BP_DATA_W-1:0]       o_dn_data,
   input  logic                       i_up_valid,
   output logic                       o_up_ready,
   input  logic [BP_DATA_W-1:0]       i_up_data,
   input  logic [1:0]                 i_up_resp,
   output logic [N_REQ-1:0]           o_rep_valid,
   input  logic [N_REQ-1:0]           i_rep_ready,
   output logic [BP_DATA_W-1:0]       o_rep_data,
   output logic [1:0]                 o_rep_resp,
   output logic                       o_orphanRep
);

   localparam int IDX_W = $clog2(N_REQ);

   // Cyclic first-eligible search starting at ptr; MSB of the result flags a winner.
   function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] elig,
                                              input logic [IDX_W-1:0] ptr);
      logic [IDX_W:0] res;
      int             j;
      res = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         j = (int'(ptr) + k) % N_REQ;
         if (elig[j]) res = {1'b1, IDX_W'(j)};
      end
      return res;
   endfunction

   logic [BP_NB_W-1:0]   w_nb_a   [N_REQ];
   logic [BP_ADDR_W-1:0] w_addr_a [N_REQ];
   logic [BP_DATA_W-1:0] w_data_a [N_REQ];

   for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
      assign w_nb_a[g]   = i_req_nBytes[g*BP_NB_W +: BP_NB_W];
      assign w_addr_a[g] = i_req_addr[g*BP_ADDR_W +: BP_ADDR_W];
      assign w_data_a[g] = i_req_data[g*BP_DATA_W +: BP_DATA_W];
   end

   bp_pkt_t              r_dn;
   logic                 r_dn_valid;
   logic [IDX_W-1:0]     r_rr_ptr;
   logic                 r_last_vld;
   logic [IDX_W-1:0]     r_last_owner;
   logic [BP_ADDR_W-1:0] r_shadow [N_REQ];
   logic                 r_orphan;

   logic [N_REQ-1:0]     w_elig;
   logic [IDX_W:0]       w_pick;
   logic                 w_pick_vld;
   logic [IDX_W-1:0]     w_idx;
   logic                 w_load;
   logic                 w_accept;
   bp_pkt_t              w_sel;
   bp_pkt_t              w_dn_nxt;
   logic                 w_rewrite;
   logic [BP_ADDR_W-1:0] w_eff;
   logic [BP_ADDR_W-1:0] w_shadow_nxt;
   logic [IDX_W-1:0]     w_rr_nxt;
   logic                 w_fifo_full;
   logic                 w_fifo_empty;
   logic [IDX_W-1:0]     w_head;
   logic                 w_pop;

   always_comb begin
      w_elig = '0;
      for (int i = 0; i < N_REQ; i++)
         w_elig[i] = i_req_valid[i] && !(i_req_readNotWrite[i] && w_fifo_full);
   end

   assign w_pick     = rr_pick(w_elig, r_rr_ptr);
   assign w_pick_vld = w_pick[IDX_W];
   assign w_idx      = w_pick[IDX_W-1:0];
   assign w_load     = !r_dn_valid || i_dn_ready;
   assign w_accept   = i_rst_n && w_load && w_pick_vld;

   always_comb begin
      w_sel.rnw    = i_req_readNotWrite[w_idx];
      w_sel.incr   = i_req_incrAddr[w_idx];
      w_sel.prev   = i_req_prevAddr[w_idx];
      w_sel.nbytes = w_nb_a[w_idx];
      w_sel.addr   = w_addr_a[w_idx];
      w_sel.data   = w_data_a[w_idx];
   end

   // Downstream only remembers the last address it saw, so prevAddr from a
   // different owner must be replaced by that requester's own shadow address.
   assign w_rewrite    = w_sel.prev && (!r_last_vld || (r_last_owner != w_idx));
   assign w_eff        = w_sel.prev ? r_shadow[w_idx] : w_sel.addr;
   assign w_shadow_nxt = w_sel.incr ? (w_eff + {{(BP_ADDR_W-BP_NB_W){1'b0}}, w_sel.nbytes})
                                    : w_eff;
   assign w_rr_nxt     = (w_idx == IDX_W'(N_REQ - 1)) ? '0 : (w_idx + IDX_W'(1));

   always_comb begin
      w_dn_nxt = w_sel;
      if (w_rewrite) begin
         w_dn_nxt.prev = 1'b0;
         w_dn_nxt.addr = r_shadow[w_idx];
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_dn         <= '0;
         r_dn_valid   <= 1'b0;
         r_rr_ptr     <= '0;
         r_last_vld   <= 1'b0;
         r_last_owner <= '0;
         r_orphan     <= 1'b0;
         for (int i = 0; i < N_REQ; i++) r_shadow[i] <= '0;
      end else begin
         if (w_load) begin
            r_dn_valid <= w_accept;
            if (w_accept) begin
               r_dn              <= w_dn_nxt;
               r_rr_ptr          <= w_rr_nxt;
               r_last_vld        <= 1'b1;
               r_last_owner      <= w_idx;
               r_shadow[w_idx]   <= w_shadow_nxt;
            end
         end
         if (i_up_valid && w_fifo_empty) r_orphan <= 1'b1;
      end
   end

   always_comb begin
      o_req_ready = '0;
      if (w_accept) o_req_ready[w_idx] = 1'b1;
   end

   bp_owner_fifo #(
      .W     (IDX_W),
      .DEPTH (OUTSTANDING)
   ) u_owner_fifo (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_push     (w_accept && w_sel.rnw),
      .i_push_dat (w_idx),
      .i_pop      (w_pop),
      .o_head_dat (w_head),
      .o_full     (w_fifo_full),
      .o_empty    (w_fifo_empty)
   );

   // Reply path is pure wiring; with nothing outstanding the reply is swallowed.
   always_comb begin
      o_rep_valid = '0;
      o_up_ready  = 1'b1;
      w_pop       = 1'b0;
      if (!w_fifo_empty) begin
         o_rep_valid[w_head] = i_up_valid;
         o_up_ready          = i_rep_ready[w_head];
         w_pop               = i_up_valid && i_rep_ready[w_head];
      end
   end

   assign o_rep_data        = i_up_data;
   assign o_rep_resp        = i_up_resp;
   assign o_orphanRep       = r_orphan;

   assign o_dn_valid        = r_dn_valid;
   assign o_dn_readNotWrite = r_dn.rnw;
   assign o_dn_incrAddr     = r_dn.incr;
   assign o_dn_prevAddr     = r_dn.prev;
   assign o_dn_nBytes       = r_dn.nbytes;
   assign o_dn_addr         = r_dn.addr;
   assign o_dn_data         = r_dn.data;

endmodule

// File: tb/tb_bp_req_arbiter.sv
// Directed bench for bp_req_arbiter (N_REQ=2, OUTSTANDING=4): arbitration order,
// prevAddr rewrite, owner FIFO stall and reply routing, orphan flag, reset.
module tb_bp_req_arbiter;

   localparam int N = 2;

   logic          i_clk = 1'b0;
   logic          i_rst_n;
   logic [N-1:0]  i_req_valid, o_req_ready, i_req_readNotWrite, i_req_incrAddr, i_req_prevAddr;
   logic [4*N-1:0]  i_req_nBytes;
   logic [64*N-1:0] i_req_addr, i_req_data;
   logic          o_dn_valid, i_dn_ready, o_dn_readNotWrite, o_dn_incrAddr, o_dn_prevAddr;
   logic [3:0]    o_dn_nBytes;
   logic [63:0]   o_dn_addr, o_dn_data;
   logic          i_up_valid, o_up_ready;
   logic [63:0]   i_up_data;
   logic [1:0]    i_up_resp;
   logic [N-1:0]  o_rep_valid, i_rep_ready;
   logic [63:0]   o_rep_data;
   logic [1:0]    o_rep_resp;
   logic          o_orphanRep;

   int n_chk = 0;
   int n_err = 0;

   bp_req_arbiter #(.N_REQ(N), .OUTSTANDING(4)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
      .i_req_readNotWrite(i_req_readNotWrite), .i_req_incrAddr(i_req_incrAddr),
      .i_req_prevAddr(i_req_prevAddr), .i_req_nBytes(i_req_nBytes),
      .i_req_addr(i_req_addr), .i_req_data(i_req_data),
      .o_dn_valid(o_dn_valid), .i_dn_ready(i_dn_ready),
      .o_dn_readNotWrite(o_dn_readNotWrite), .o_dn_incrAddr(o_dn_incrAddr),
      .o_dn_prevAddr(o_dn_prevAddr), .o_dn_nBytes(o_dn_nBytes),
      .o_dn_addr(o_dn_addr), .o_dn_data(o_dn_data),
      .i_up_valid(i_up_valid), .o_up_ready(o_up_ready),
      .i_up_data(i_up_data), .i_up_resp(i_up_resp),
      .o_rep_valid(o_rep_valid), .i_rep_ready(i_rep_ready),
      .o_rep_data(o_rep_data), .o_rep_resp(o_rep_resp),
      .o_orphanRep(o_orphanRep)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #2;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle();
      i_req_valid = '0; i_req_readNotWrite = '0; i_req_incrAddr = '0; i_req_prevAddr = '0;
      i_req_nBytes = '0; i_req_addr = '0; i_req_data = '0;
      i_dn_ready = 1'b1; i_up_valid = 1'b0; i_up_data = '0; i_up_resp = '0; i_rep_ready = '0;
   endtask

   task automatic do_reset();
      idle();
      i_rst_n = 1'b0;
      tick();
      tick();
      i_rst_n = 1'b1;
      settle();
   endtask

   task automatic set_req(input int r, input logic vld, input logic rnw, input logic incr,
                          input logic prev, input logic [3:0] nb, input logic [63:0] addr,
                          input logic [63:0] data);
      i_req_valid[r]        = vld;
      i_req_readNotWrite[r] = rnw;
      i_req_incrAddr[r]     = incr;
      i_req_prevAddr[r]     = prev;
      i_req_nBytes[r*4 +: 4]   = nb;
      i_req_addr[r*64 +: 64]   = addr;
      i_req_data[r*64 +: 64]   = data;
   endtask

   initial begin
      // 1: reset with random inputs
      idle();
      i_rst_n = 1'b0;
      for (int c = 0; c < 4; c++) begin
         i_req_valid = N'($urandom); i_req_readNotWrite = N'($urandom);
         i_req_prevAddr = N'($urandom); i_req_addr = {$urandom, $urandom, $urandom, $urandom};
         i_dn_ready = 1'($urandom); i_up_valid = 1'($urandom); i_rep_ready = N'($urandom);
         tick();
      end
      chk("rst_dn_valid", 64'(o_dn_valid), 64'd0);
      chk("rst_rep_valid", 64'(o_rep_valid), 64'd0);
      chk("rst_orphan", 64'(o_orphanRep), 64'd0);
      chk("rst_req_ready", 64'(o_req_ready), 64'd0);
      do_reset();

      // 2: round-robin between two writers
      set_req(0, 1, 0, 0, 0, 4'd8, 64'hA0, 64'h1111);
      set_req(1, 1, 0, 0, 0, 4'd8, 64'hB0, 64'h2222);
      settle();
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("rr_ready%0d", k), 64'(o_req_ready), 64'(1 << (k % 2)));
         tick();
         settle();
         chk($sformatf("rr_dn_valid%0d", k), 64'(o_dn_valid), 64'd1);
         chk($sformatf("rr_dn_addr%0d", k), o_dn_addr, (k % 2) ? 64'hB0 : 64'hA0);
      end
      idle();
      tick();
      chk("rr_drain", 64'(o_dn_valid), 64'd0);

      // 3: prevAddr rewrite against the per-requester shadow
      do_reset();
      set_req(0, 1, 0, 1, 0, 4'd4, 64'h100, 64'h0);
      settle();
      chk("pa_ready0", 64'(o_req_ready), 64'd1);
      tick();
      idle();
      set_req(1, 1, 0, 0, 1, 4'd8, 64'hDEAD, 64'h5);
      settle();
      chk("pa_dn0_addr", o_dn_addr, 64'h100);
      chk("pa_dn0_incr", 64'(o_dn_incrAddr), 64'd1);
      chk("pa_ready1", 64'(o_req_ready), 64'd2);
      tick();
      settle();
      chk("pa_rewrite_prev", 64'(o_dn_prevAddr), 64'd0);
      chk("pa_rewrite_addr", o_dn_addr, 64'h0);
      tick();
      settle();
      chk("pa_pass_prev", 64'(o_dn_prevAddr), 64'd1);
      chk("pa_pass_addr", o_dn_addr, 64'hDEAD);
      // shadow wraps mod 2^64
      idle();
      set_req(0, 1, 0, 1, 0, 4'd4, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0);
      tick();
      idle();
      set_req(1, 1, 0, 0, 0, 4'd1, 64'h200, 64'h0);
      tick();
      idle();
      set_req(0, 1, 0, 0, 1, 4'd1, 64'h777, 64'h0);
      tick();
      idle();
      settle();
      chk("pa_wrap_addr", o_dn_addr, 64'h0);
      chk("pa_wrap_prev", 64'(o_dn_prevAddr), 64'd0);

      // 4: owner FIFO fills, writes still pass, replies routed in order
      do_reset();
      set_req(1, 1, 1, 0, 0, 4'd8, 64'h40, 64'h0);
      settle();
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("of_rd_ready%0d", k), 64'(o_req_ready), 64'd2);
         tick();
         settle();
      end
      chk("of_full_stall", 64'(o_req_ready), 64'd0);
      set_req(0, 1, 0, 0, 0, 4'd4, 64'h88, 64'h99);
      settle();
      chk("of_wr_ready", 64'(o_req_ready), 64'd1);
      tick();
      idle();
      settle();
      chk("of_wr_dn_rnw", 64'(o_dn_readNotWrite), 64'd0);
      chk("of_wr_dn_addr", o_dn_addr, 64'h88);
      i_up_valid = 1'b1;
      i_up_data = 64'h1000;
      i_rep_ready = 2'b00;
      settle();
      chk("of_rep_bp_valid", 64'(o_rep_valid), 64'd2);
      chk("of_rep_bp_upready", 64'(o_up_ready), 64'd0);
      i_rep_ready = 2'b10;
      for (int k = 0; k < 4; k++) begin
         i_up_data = 64'h1000 + 64'(k);
         i_up_resp = 2'(k);
         settle();
         chk($sformatf("of_rep_valid%0d", k), 64'(o_rep_valid), 64'd2);
         chk($sformatf("of_up_ready%0d", k), 64'(o_up_ready), 64'd1);
         chk($sformatf("of_rep_data%0d", k), o_rep_data, 64'h1000 + 64'(k));
         chk($sformatf("of_rep_resp%0d", k), 64'(o_rep_resp), 64'(k));
         tick();
      end
      i_up_valid = 1'b0;
      settle();
      chk("of_rep_done", 64'(o_rep_valid), 64'd0);
      chk("of_no_orphan", 64'(o_orphanRep), 64'd0);

      // 5: reply with nothing outstanding
      i_up_valid = 1'b1;
      settle();
      chk("or_up_ready", 64'(o_up_ready), 64'd1);
      chk("or_rep_valid", 64'(o_rep_valid), 64'd0);
      tick();
      i_up_valid = 1'b0;
      settle();
      chk("or_set", 64'(o_orphanRep), 64'd1);
      tick();
      tick();
      chk("or_sticky", 64'(o_orphanRep), 64'd1);

      // 6: reset while a packet is held and two reads are outstanding
      do_reset();
      chk("rs_orphan_clr", 64'(o_orphanRep), 64'd0);
      set_req(1, 1, 1, 0, 0, 4'd8, 64'h300, 64'h0);
      tick();
      set_req(1, 1, 1, 0, 0, 4'd8, 64'h308, 64'h0);
      tick();
      idle();
      i_dn_ready = 1'b0;
      set_req(0, 1, 0, 0, 0, 4'd4, 64'h400, 64'h0);
      settle();
      chk("rs_hold_ready", 64'(o_req_ready), 64'd0);
      tick();
      chk("rs_hold_valid", 64'(o_dn_valid), 64'd1);
      chk("rs_hold_addr", o_dn_addr, 64'h308);
      i_rst_n = 1'b0;
      settle();
      chk("rs_dn_valid", 64'(o_dn_valid), 64'd0);
      tick();
      i_rst_n = 1'b1;
      idle();
      i_up_valid = 1'b1;
      settle();
      chk("rs_rep_valid", 64'(o_rep_valid), 64'd0);
      chk("rs_up_ready", 64'(o_up_ready), 64'd1);
      tick();
      i_up_valid = 1'b0;
      settle();
      chk("rs_orphan", 64'(o_orphanRep), 64'd1);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
